// File: rtl/mem_spi_pkg.sv
// Constants, state encoding and frame helpers shared by the SPI memory read/write engines.
// MEM_WRITE_WREN_EN adds the WREN/GAP states used for the write-enable preamble.
package mem_spi_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SPI_CMD_WREN  = 8'h06;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int FRAME_W = 64;
  localparam int LEN_W   = 7;

`ifdef MEM_WRITE_WREN_EN
  typedef enum logic [2:0] {IDLE, SHIFT, DONE, WREN, GAP} wr_state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} wr_state_e;
`endif

  // Encoding 11 is treated as a word store.
  function automatic logic [LEN_W-1:0] frame_len(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 7'd40;
      SIZE_HALF: return 7'd48;
      default:   return 7'd64;
    endcase
  endfunction

  // Left-aligned frame; bytes beyond the frame length are never shifted out.
  function automatic logic [FRAME_W-1:0] write_frame(input logic [23:0] addr,
                                                     input logic [31:0] data);
    return {SPI_CMD_WRITE, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
  endfunction

endpackage

// File: rtl/spi_shift_out.sv
// MSB-first SPI mode-0 serialiser: two clk cycles per bit, sclk low then high.
module spi_shift_out
  import mem_spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               sclk_o,
  output logic               mosi_o,
  output logic               last_o
);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic               active_q, active_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    active_d = active_q;
    if (load_i) begin
      shift_d  = frame_i;
      cnt_d    = len_i;
      phase_d  = 1'b0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        // End of high phase: advance to the next bit.
        phase_d = 1'b0;
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        cnt_d   = cnt_q - 7'd1;
        if (cnt_q == 7'd1) active_d = 1'b0;
      end
    end
  end

  assign sclk_o = active_q & phase_q;
  assign mosi_o = active_q & shift_q[FRAME_W-1];
  assign last_o = active_q & phase_q & (cnt_q == 7'd1);

endmodule

// File: rtl/mem_write.sv
// SPI memory write engine: latches a store request and sends 0x02 + address + data.
// Define MEM_WRITE_WREN_EN to prefix each write with a WREN (0x06) command frame.
module mem_write
  import mem_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] target_address,
  input  logic [31:0] write_data,
  input  logic [1:0]  write_size,
  input  logic        start_write,
  output logic        write_done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs
);

  wr_state_e          state_q, state_d;
  logic               load;
  logic [FRAME_W-1:0] frame;
  logic [LEN_W-1:0]   len;
  logic               last;

`ifdef MEM_WRITE_WREN_EN
  // The write frame is built after the preamble, so the request must be held here.
  logic [23:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
    end else if (state_q == IDLE && start_write) begin
      addr_q <= target_address;
      data_q <= write_data;
      size_q <= write_size;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef MEM_WRITE_WREN_EN
      IDLE:  if (start_write) state_d = WREN;
      WREN:  if (last) state_d = GAP;
      GAP:   state_d = SHIFT;
`else
      IDLE:  if (start_write) state_d = SHIFT;
`endif
      SHIFT: if (last) state_d = DONE;
      DONE:  if (!start_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load       = 1'b0;
    frame      = '0;
    len        = '0;
    cs         = 1'b1;
    write_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_write) begin
          load = 1'b1;
`ifdef MEM_WRITE_WREN_EN
          frame = {SPI_CMD_WREN, 56'd0};
          len   = 7'd8;
`else
          frame = write_frame(target_address, write_data);
          len   = frame_len(write_size);
`endif
        end
      end
`ifdef MEM_WRITE_WREN_EN
      WREN: cs = 1'b0;
      GAP: begin
        load  = 1'b1;
        frame = write_frame(addr_q, data_q);
        len   = frame_len(size_q);
      end
`endif
      SHIFT: cs = 1'b0;
      DONE:  write_done = 1'b1;
      default: ;
    endcase
  end

  spi_shift_out u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .frame_i (frame),
    .len_i   (len),
    .sclk_o  (sclk),
    .mosi_o  (mosi),
    .last_o  (last)
  );

endmodule

// File: tb/tb_mem_write.sv
// Scoreboard bench for mem_write: expected MOSI bytes queued at request time, compared after done.
`timescale 1ns/1ps
module tb_mem_write;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] target_address = '0;
  logic [31:0] write_data = '0;
  logic [1:0]  write_size = '0;
  logic        start_write = 1'b0;
  logic        write_done, sclk, mosi, cs;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         bit_cnt = 0;
  int         stab_err = 0;
  int         idle_err = 0;
  logic [7:0] rx_sh = '0;
  logic       lo_mosi = 1'b0;

`ifdef MEM_WRITE_WREN_EN
  localparam int PRE_EDGES = 17;
  localparam int PRE_LOW   = 16;
  localparam int PRE_HIGH  = 1;
`else
  localparam int PRE_EDGES = 0;
  localparam int PRE_LOW   = 0;
  localparam int PRE_HIGH  = 0;
`endif

  mem_write dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .target_address (target_address),
    .write_data     (write_data),
    .write_size     (write_size),
    .start_write    (start_write),
    .write_done     (write_done),
    .sclk           (sclk),
    .mosi           (mosi),
    .cs             (cs)
  );

  always #5 clk = ~clk;

  // SPI receiver: one bit per sclk-high phase, mosi must not move while sclk is high.
  always @(negedge clk) begin
    if (cs === 1'b1) begin
      bit_cnt = 0;
      if (mosi !== 1'b0) idle_err++;
    end else if (sclk === 1'b1) begin
      if (mosi !== lo_mosi) stab_err++;
      rx_sh = {rx_sh[6:0], mosi};
      bit_cnt++;
      if (bit_cnt == 8) begin
        rx_q.push_back(rx_sh);
        bit_cnt = 0;
      end
    end else begin
      lo_mosi = mosi;
    end
  end

  task automatic push_expected(input logic [23:0] a, input logic [31:0] d, input logic [1:0] s);
    int nb;
    nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
`ifdef MEM_WRITE_WREN_EN
    exp_q.push_back(8'h06);
`endif
    exp_q.push_back(8'h02);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    for (int i = 0; i < nb; i++) exp_q.push_back(d[8*i +: 8]);
  endtask

  // Drives one request and measures timing relative to E0 (sampled 1ns after each edge).
  task automatic drive_frame(input logic [23:0] a, input logic [31:0] d, input logic [1:0] s,
                             input int drop_at, input int chg_at, input int hold, input int rst_at,
                             output int done_edge, output int cs_low, output int cs_high,
                             output int done_cyc, output logic [3:0] rst_obs);
    int e;
    bit seen;
    done_edge = -1; cs_low = 0; cs_high = 0; done_cyc = 0; rst_obs = '0; seen = 0;
    @(negedge clk);
    target_address = a; write_data = d; write_size = s; start_write = 1'b1;
    push_expected(a, d, s);
    @(posedge clk);
    e = 0;
    while (1) begin
      #1;
      if (!seen) begin
        if (write_done === 1'b1) begin
          seen = 1; done_edge = e; done_cyc = 1;
        end else if (cs === 1'b1) cs_high++;
        else cs_low++;
      end else if (write_done === 1'b1) done_cyc++;
      else break;
      if (e == chg_at) begin
        write_data = ~d; target_address = ~a; write_size = ~s;
      end
      if (e == drop_at) start_write = 1'b0;
      if (seen && e == done_edge + hold) start_write = 1'b0;
      if (e == rst_at) begin
        rst_n = 1'b0;
        #1;
        rst_obs = {cs, sclk, mosi, write_done};
        start_write = 1'b0;
        break;
      end
      if (e >= 600) begin
        vectors++; miscompares++;
        $display("FAIL timeout: no completion, edges=%0d required<600", e);
        start_write = 1'b0;
        break;
      end
      @(posedge clk);
      e++;
    end
    $display("txn addr=%06h data=%08h size=%0d done_edge=%0d cs_low=%0d done_cycles=%0d",
             a, d, s, done_edge, cs_low, done_cyc);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++; if (cs !== 1'b1)         begin miscompares++; $display("FAIL reset_cs got %b want 1", cs); end
    vectors++; if (sclk !== 1'b0)       begin miscompares++; $display("FAIL reset_sclk got %b want 0", sclk); end
    vectors++; if (mosi !== 1'b0)       begin miscompares++; $display("FAIL reset_mosi got %b want 0", mosi); end
    vectors++; if (write_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", write_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word;
    int de, cl, ch, dc; logic [3:0] ro; logic [7:0] ev, rv;
    drive_frame(24'h000010, 32'hDEADBEEF, 2'b10, -1, -1, 0, -1, de, cl, ch, dc, ro);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = (rx_q.size() > 0) ? rx_q.pop_front() : ~ev;
      vectors++; if (rv !== ev) begin miscompares++; $display("FAIL word_byte got %02h want %02h", rv, ev); end
    end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL word_extra got %0d bytes want 0", rx_q.size()); rx_q.delete(); end
    vectors++; if (de != PRE_EDGES + 128) begin miscompares++; $display("FAIL word_done_edge got %0d want %0d", de, PRE_EDGES + 128); end
    vectors++; if (cl != PRE_LOW + 128)   begin miscompares++; $display("FAIL word_cs_low got %0d want %0d", cl, PRE_LOW + 128); end
    vectors++; if (ch != PRE_HIGH)        begin miscompares++; $display("FAIL word_cs_gap got %0d want %0d", ch, PRE_HIGH); end
    vectors++; if (dc != 1)               begin miscompares++; $display("FAIL word_done_len got %0d want 1", dc); end
  endtask

  task automatic test_byte;
    int de, cl, ch, dc; logic [3:0] ro; logic [7:0] ev, rv;
    drive_frame(24'hABCDEF, 32'h12345678, 2'b00, -1, -1, 0, -1, de, cl, ch, dc, ro);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = (rx_q.size() > 0) ? rx_q.pop_front() : ~ev;
      vectors++; if (rv !== ev) begin miscompares++; $display("FAIL byte_byte got %02h want %02h", rv, ev); end
    end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL byte_extra got %0d bytes want 0", rx_q.size()); rx_q.delete(); end
    vectors++; if (de != PRE_EDGES + 80) begin miscompares++; $display("FAIL byte_done_edge got %0d want %0d", de, PRE_EDGES + 80); end
    vectors++; if (cl != PRE_LOW + 80)   begin miscompares++; $display("FAIL byte_cs_low got %0d want %0d", cl, PRE_LOW + 80); end
  endtask

  task automatic test_half_drop;
    int de, cl, ch, dc; logic [3:0] ro; logic [7:0] ev, rv;
    drive_frame(24'h00A5C3, 32'h12345678, 2'b01, 20, -1, 0, -1, de, cl, ch, dc, ro);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = (rx_q.size() > 0) ? rx_q.pop_front() : ~ev;
      vectors++; if (rv !== ev) begin miscompares++; $display("FAIL half_byte got %02h want %02h", rv, ev); end
    end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL half_extra got %0d bytes want 0", rx_q.size()); rx_q.delete(); end
    vectors++; if (de != PRE_EDGES + 96) begin miscompares++; $display("FAIL half_done_edge got %0d want %0d", de, PRE_EDGES + 96); end
    vectors++; if (dc != 1)              begin miscompares++; $display("FAIL half_done_pulse got %0d want 1", dc); end
  endtask

  task automatic test_reset_mid;
    int de, cl, ch, dc; logic [3:0] ro; logic [7:0] ev, rv;
    drive_frame(24'h000010, 32'hDEADBEEF, 2'b10, -1, -1, 0, 40, de, cl, ch, dc, ro);
    vectors++; if (ro !== 4'b1000) begin miscompares++; $display("FAIL abort_outputs got cs/sclk/mosi/done=%b want 1000", ro); end
    vectors++; if (de != -1)       begin miscompares++; $display("FAIL abort_no_done got %0d want -1", de); end
    repeat (3) @(negedge clk);
    vectors++; if (write_done !== 1'b0 || cs !== 1'b1) begin
      miscompares++; $display("FAIL abort_hold got done=%b cs=%b want done=0 cs=1", write_done, cs);
    end
    rst_n = 1'b1;
    exp_q.delete(); rx_q.delete();
    drive_frame(24'h7E0001, 32'hCAFEF00D, 2'b10, -1, -1, 0, -1, de, cl, ch, dc, ro);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = (rx_q.size() > 0) ? rx_q.pop_front() : ~ev;
      vectors++; if (rv !== ev) begin miscompares++; $display("FAIL abort_retry_byte got %02h want %02h", rv, ev); end
    end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL abort_retry_extra got %0d bytes want 0", rx_q.size()); rx_q.delete(); end
    vectors++; if (de != PRE_EDGES + 128) begin miscompares++; $display("FAIL abort_retry_done got %0d want %0d", de, PRE_EDGES + 128); end
  endtask

  task automatic test_stability;
    int de, cl, ch, dc; logic [3:0] ro; logic [7:0] ev, rv;
    drive_frame(24'h3C5A96, 32'h0BADCAFE, 2'b10, -1, 2, 5, -1, de, cl, ch, dc, ro);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = (rx_q.size() > 0) ? rx_q.pop_front() : ~ev;
      vectors++; if (rv !== ev) begin miscompares++; $display("FAIL stable_byte got %02h want %02h", rv, ev); end
    end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL stable_extra got %0d bytes want 0", rx_q.size()); rx_q.delete(); end
    vectors++; if (de != PRE_EDGES + 128) begin miscompares++; $display("FAIL stable_done_edge got %0d want %0d", de, PRE_EDGES + 128); end
    vectors++; if (dc != 6)               begin miscompares++; $display("FAIL stable_done_hold got %0d want 6", dc); end
  endtask

  task automatic test_size11;
    int de, cl, ch, dc; logic [3:0] ro; logic [7:0] ev, rv;
    drive_frame(24'hFFFFFF, 32'h80402010, 2'b11, -1, -1, 0, -1, de, cl, ch, dc, ro);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = (rx_q.size() > 0) ? rx_q.pop_front() : ~ev;
      vectors++; if (rv !== ev) begin miscompares++; $display("FAIL size11_byte got %02h want %02h", rv, ev); end
    end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL size11_extra got %0d bytes want 0", rx_q.size()); rx_q.delete(); end
    vectors++; if (de != PRE_EDGES + 128) begin miscompares++; $display("FAIL size11_done_edge got %0d want %0d", de, PRE_EDGES + 128); end
  endtask

  task automatic test_back_to_back;
    int de1, de2, cl, ch, dc; logic [3:0] ro; logic [7:0] ev, rv;
    drive_frame(24'h010203, 32'h000000A1, 2'b00, -1, -1, 0, -1, de1, cl, ch, dc, ro);
    drive_frame(24'h040506, 32'h0000B2C3, 2'b01, -1, -1, 0, -1, de2, cl, ch, dc, ro);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = (rx_q.size() > 0) ? rx_q.pop_front() : ~ev;
      vectors++; if (rv !== ev) begin miscompares++; $display("FAIL b2b_byte got %02h want %02h", rv, ev); end
    end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL b2b_extra got %0d bytes want 0", rx_q.size()); rx_q.delete(); end
    vectors++; if (de1 != PRE_EDGES + 80) begin miscompares++; $display("FAIL b2b_done1 got %0d want %0d", de1, PRE_EDGES + 80); end
    vectors++; if (de2 != PRE_EDGES + 96) begin miscompares++; $display("FAIL b2b_done2 got %0d want %0d", de2, PRE_EDGES + 96); end
  endtask

  task automatic test_line_rules;
    vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL mosi_stable got %0d changes want 0", stab_err); end
    vectors++; if (idle_err != 0) begin miscompares++; $display("FAIL mosi_idle got %0d nonzero want 0", idle_err); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half_drop();
    test_reset_mid();
    test_stability();
    test_size11();
    test_back_to_back();
    test_line_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
